// File: rtl/oled_pkg.sv
// Shared types, SSD1306 command codes and decoder state for the OLED SPI receive model.
package oled_pkg;

  localparam int NUM_PAGES = 8;
  localparam int NUM_COLS  = 128;

  typedef logic [2:0] page_t;
  typedef logic [6:0] col_t;

  localparam logic [7:0] CMD_SET_COL_LO    = 8'h00;
  localparam logic [7:0] CMD_SET_COL_HI    = 8'h10;
  localparam logic [7:0] CMD_SET_PAGE_BASE = 8'hB0;
  localparam logic [7:0] CMD_SET_MEM_MODE  = 8'h20;
  localparam logic [7:0] CMD_SET_COL_ADDR  = 8'h21;
  localparam logic [7:0] CMD_SET_PAGE_ADDR = 8'h22;
  localparam logic [7:0] CMD_SET_CONTRAST  = 8'h81;
  localparam logic [7:0] CMD_CHARGE_PUMP   = 8'h8D;
  localparam logic [7:0] CMD_SET_MUX       = 8'hA8;
  localparam logic [7:0] CMD_SET_OFFSET    = 8'hD3;
  localparam logic [7:0] CMD_SET_CLKDIV    = 8'hD5;
  localparam logic [7:0] CMD_SET_PRECHARGE = 8'hD9;
  localparam logic [7:0] CMD_SET_COMPINS   = 8'hDA;
  localparam logic [7:0] CMD_SET_VCOMH     = 8'hDB;

  typedef enum logic {CMD_IDLE, CMD_SKIP} dec_state_t;

  // Number of argument bytes that follow a command opcode (0 = none / not tracked).
  function automatic logic [1:0] arg_count(input logic [7:0] code);
    case (code)
      CMD_SET_CONTRAST, CMD_CHARGE_PUMP, CMD_SET_MUX, CMD_SET_OFFSET,
      CMD_SET_CLKDIV, CMD_SET_PRECHARGE, CMD_SET_COMPINS, CMD_SET_VCOMH,
      CMD_SET_MEM_MODE:                    arg_count = 2'd1;
      CMD_SET_COL_ADDR, CMD_SET_PAGE_ADDR: arg_count = 2'd2;
      default:                             arg_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver: synchronizes the four pins, detects spi_clk rises and
// assembles MSB-first bytes; cs_n high drops any partial byte.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  input  logic       spi_cs_n,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);

  logic [SYNC_STAGES-1:0] sclk_q, mosi_q, dc_q, csn_q;
  logic       sclk_prev_q;
  logic [6:0] shift_q;
  logic [2:0] cnt_q;
  logic       valid_q;
  logic [7:0] data_q;
  logic       dc_out_q;

  logic sclk_s, mosi_s, dc_s, csn_s, rise;

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign dc_s   = dc_q[SYNC_STAGES-1];
  assign csn_s  = csn_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q      <= '0;
      mosi_q      <= '0;
      dc_q        <= '0;
      csn_q       <= '1;
      sclk_prev_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      dc_out_q    <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], spi_clk};
      mosi_q      <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      dc_q        <= {dc_q[SYNC_STAGES-2:0], spi_dc};
      csn_q       <= {csn_q[SYNC_STAGES-2:0], spi_cs_n};
      sclk_prev_q <= sclk_s;
      valid_q     <= 1'b0;
      if (csn_s) begin
        cnt_q <= '0;
      end else if (rise) begin
        shift_q <= {shift_q[5:0], mosi_s};
        cnt_q   <= cnt_q + 3'd1;  // wraps 7 -> 0 on the eighth bit
        if (cnt_q == 3'd7) begin
          valid_q  <= 1'b1;
          data_q   <= {shift_q, mosi_s};
          dc_out_q <= dc_s;
        end
      end
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = data_q;
  assign byte_dc    = dc_out_q;

endmodule

// File: rtl/oled_spi_rx.sv
// OLED SPI receive model: decodes the SSD1306 page-addressing subset and emits
// framebuffer writes. Define OLED_SPI_RX_ADDR_WIN_EN for 0x21/0x22 address windows.
import oled_pkg::*;

module oled_spi_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_PAGES   = 8,
  parameter int NUM_COLS    = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  input  logic       spi_cs_n,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       wr_en,
  output logic [2:0] wr_page,
  output logic [6:0] wr_col,
  output logic [7:0] wr_data,
  output logic [2:0] cur_page,
  output logic [6:0] cur_col
);

  localparam col_t  COL_LAST  = col_t'(NUM_COLS - 1);
  localparam page_t PAGE_LAST = page_t'(NUM_PAGES - 1);

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_byte_rx (
    .clk(clk), .rst(rst),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_dc(spi_dc), .spi_cs_n(spi_cs_n),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc)
  );

  dec_state_t state_q, state_d;
  logic [1:0] skip_q, skip_d;
  page_t      cur_page_q, cur_page_d, wr_page_q, wr_page_d;
  col_t       cur_col_q, cur_col_d, wr_col_q, wr_col_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_data_q, wr_data_d;

`ifdef OLED_SPI_RX_ADDR_WIN_EN
  col_t  col_start_q, col_start_d, col_end_q, col_end_d;
  page_t page_start_q, page_start_d, page_end_q, page_end_d;
  logic  arg_col_q, arg_col_d;
`endif

  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    cur_page_d = cur_page_q;
    cur_col_d  = cur_col_q;
    wr_en_d    = 1'b0;
    wr_page_d  = wr_page_q;
    wr_col_d   = wr_col_q;
    wr_data_d  = wr_data_q;
`ifdef OLED_SPI_RX_ADDR_WIN_EN
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    arg_col_d    = arg_col_q;
`endif
    if (byte_valid) begin
      if (byte_dc) begin
        // Data bytes are written in either decoder state.
        wr_en_d   = 1'b1;
        wr_page_d = cur_page_q;
        wr_col_d  = cur_col_q;
        wr_data_d = byte_data;
`ifdef OLED_SPI_RX_ADDR_WIN_EN
        if (cur_col_q == col_end_q) begin
          cur_col_d  = col_start_q;
          cur_page_d = (cur_page_q == page_end_q) ? page_start_q : cur_page_q + 3'd1;
        end else begin
          cur_col_d = cur_col_q + 7'd1;
        end
`else
        cur_col_d = (cur_col_q == COL_LAST) ? '0 : cur_col_q + 7'd1;
`endif
      end else if (state_q == CMD_SKIP) begin
        skip_d = skip_q - 2'd1;
        if (skip_q == 2'd1) state_d = CMD_IDLE;
`ifdef OLED_SPI_RX_ADDR_WIN_EN
        if (arg_col_q) begin
          if (skip_q == 2'd2) col_start_d = byte_data[6:0];
          else begin
            col_end_d = byte_data[6:0];
            cur_col_d = col_start_q;
          end
        end else if (skip_q != 2'd0) begin
          if (skip_q == 2'd2) page_start_d = byte_data[2:0];
          else begin
            page_end_d = byte_data[2:0];
            cur_page_d = page_start_q;
          end
        end
`endif
      end else begin
        if (byte_data[7:4] == CMD_SET_COL_LO[7:4]) begin
          cur_col_d[3:0] = byte_data[3:0];
        end else if (byte_data[7:3] == CMD_SET_COL_HI[7:3]) begin
          cur_col_d[6:4] = byte_data[2:0];
        end else if (byte_data[7:3] == CMD_SET_PAGE_BASE[7:3]) begin
          if (byte_data[2:0] <= PAGE_LAST) cur_page_d = byte_data[2:0];
        end else if (arg_count(byte_data) != 2'd0) begin
          state_d = CMD_SKIP;
          skip_d  = arg_count(byte_data);
`ifdef OLED_SPI_RX_ADDR_WIN_EN
          arg_col_d = (byte_data == CMD_SET_COL_ADDR);
          if (byte_data != CMD_SET_COL_ADDR && byte_data != CMD_SET_PAGE_ADDR)
            skip_d = 2'd1;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CMD_IDLE;
      skip_q     <= '0;
      cur_page_q <= '0;
      cur_col_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_page_q  <= '0;
      wr_col_q   <= '0;
      wr_data_q  <= '0;
`ifdef OLED_SPI_RX_ADDR_WIN_EN
      col_start_q  <= '0;
      col_end_q    <= COL_LAST;
      page_start_q <= '0;
      page_end_q   <= PAGE_LAST;
      arg_col_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      cur_page_q <= cur_page_d;
      cur_col_q  <= cur_col_d;
      wr_en_q    <= wr_en_d;
      wr_page_q  <= wr_page_d;
      wr_col_q   <= wr_col_d;
      wr_data_q  <= wr_data_d;
`ifdef OLED_SPI_RX_ADDR_WIN_EN
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      arg_col_q    <= arg_col_d;
`endif
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_page  = wr_page_q;
  assign wr_col   = wr_col_q;
  assign wr_data  = wr_data_q;
  assign cur_page = cur_page_q;
  assign cur_col  = cur_col_q;

endmodule

// File: tb/tb_oled_spi_rx.sv
// Directed bench for oled_spi_rx (default build): SPI byte driver, write scoreboard
// with expected queue, and a single summary line.
module tb_oled_spi_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_dc = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_dc;
  logic       wr_en;
  logic [2:0] wr_page;
  logic [6:0] wr_col;
  logic [7:0] wr_data;
  logic [2:0] cur_page;
  logic [6:0] cur_col;

  int n_cmp = 0;
  int n_err = 0;
  int valid_cnt = 0;
  logic [7:0] last_byte = '0;
  logic       last_dc = 1'b0;
  logic       prev_data_valid = 1'b0;
  logic [17:0] exp_q[$];

  oled_spi_rx #(.SYNC_STAGES(2), .NUM_PAGES(8), .NUM_COLS(128)) dut (
    .clk(clk), .rst(rst),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_dc(spi_dc), .spi_cs_n(spi_cs_n),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
    .wr_en(wr_en), .wr_page(wr_page), .wr_col(wr_col), .wr_data(wr_data),
    .cur_page(cur_page), .cur_col(cur_col)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid) begin
        valid_cnt++;
        last_byte = byte_data;
        last_dc   = byte_dc;
      end
      if (wr_en || prev_data_valid) begin
        check("wr_timing", {31'd0, wr_en}, {31'd0, prev_data_valid});
      end
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", {14'd0, wr_page, wr_col, wr_data}, 32'hFFFF_FFFF);
        end else begin
          check("wr_addr_data", {14'd0, wr_page, wr_col, wr_data}, {14'd0, exp_q.pop_front()});
        end
      end
      prev_data_valid = byte_valid && byte_dc;
    end else begin
      prev_data_valid = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits);
    spi_cs_n = 1'b0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = b[i];
      spi_dc   = dc;
      wait_clks(4);
      spi_clk = 1'b1;
      wait_clks(4);
      spi_clk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    send_bits(b, dc, 8);
    wait_clks(2);
  endtask

  task automatic expect_write(input logic [2:0] pg, input logic [6:0] col, input logic [7:0] d);
    exp_q.push_back({pg, col, d});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_byte_valid"}, {31'd0, byte_valid}, 32'd0);
    check({tag, "_byte_data"},  {24'd0, byte_data},  32'd0);
    check({tag, "_byte_dc"},    {31'd0, byte_dc},    32'd0);
    check({tag, "_wr_en"},      {31'd0, wr_en},      32'd0);
    check({tag, "_wr_fields"},  {14'd0, wr_page, wr_col, wr_data}, 32'd0);
    check({tag, "_cur_page"},   {29'd0, cur_page},   32'd0);
    check({tag, "_cur_col"},    {25'd0, cur_col},    32'd0);
  endtask

  // ---------------- stimulus ----------------
  int v0;

  initial begin
    rst = 1'b1;
    wait_clks(3);
    check_reset_state("reset");
    rst = 1'b0;
    wait_clks(3);

    // Data byte at the origin.
    v0 = valid_cnt;
    expect_write(3'd0, 7'd0, 8'hA5);
    send_byte(8'hA5, 1'b1);
    check("a5_valid_cnt", valid_cnt - v0, 32'd1);
    check("a5_byte", {24'd0, last_byte}, 32'hA5);
    check("a5_dc", {31'd0, last_dc}, 32'd1);
    check("a5_byte_held", {24'd0, byte_data}, 32'hA5);
    check("a5_cur_col", {25'd0, cur_col}, 32'd1);

    // Page 3, column 0x25 via low/high nibble commands.
    send_byte(8'hB3, 1'b0);
    send_byte(8'h05, 1'b0);
    check("col_lo_nibble", {25'd0, cur_col}, 32'h05);
    send_byte(8'h12, 1'b0);
    check("cmd_dc_sampled", {31'd0, last_dc}, 32'd0);
    expect_write(3'd3, 7'h25, 8'h3C);
    send_byte(8'h3C, 1'b1);
    check("p3_cur_col", {25'd0, cur_col}, 32'h26);
    check("p3_cur_page", {29'd0, cur_page}, 32'd3);

    // Column 127 wraps to 0 without touching the page.
    send_byte(8'hB0, 1'b0);
    send_byte(8'h0F, 1'b0);
    send_byte(8'h17, 1'b0);
    check("col_127", {25'd0, cur_col}, 32'd127);
    expect_write(3'd0, 7'd127, 8'h11);
    send_byte(8'h11, 1'b1);
    check("wrap_col0", {25'd0, cur_col}, 32'd0);
    expect_write(3'd0, 7'd0, 8'h22);
    send_byte(8'h22, 1'b1);
    check("wrap_page", {29'd0, cur_page}, 32'd0);
    check("after_wrap_col", {25'd0, cur_col}, 32'd1);

    // Contrast argument that looks like a page command is swallowed.
    send_byte(8'h81, 1'b0);
    send_byte(8'hB5, 1'b0);
    check("arg_skipped_page", {29'd0, cur_page}, 32'd0);
    send_byte(8'hB2, 1'b0);
    check("back_to_idle_page", {29'd0, cur_page}, 32'd2);
    send_byte(8'hB0, 1'b0);

    // Column-address command: data between arguments is still written.
    send_byte(8'h21, 1'b0);
    expect_write(3'd0, 7'd1, 8'h77);
    send_byte(8'h77, 1'b1);
    send_byte(8'h10, 1'b0);
    send_byte(8'h05, 1'b0);
    check("skip2_col", {25'd0, cur_col}, 32'd2);
    send_byte(8'h03, 1'b0);
    check("skip2_idle_col", {25'd0, cur_col}, 32'd3);

    // Partial byte dropped by cs_n.
    v0 = valid_cnt;
    send_bits(8'hFF, 1'b1, 5);
    spi_cs_n = 1'b1;
    wait_clks(6);
    expect_write(3'd0, 7'd3, 8'h80);
    send_byte(8'h80, 1'b1);
    check("csn_valid_cnt", valid_cnt - v0, 32'd1);
    check("csn_byte", {24'd0, last_byte}, 32'h80);
    check("csn_cur_col", {25'd0, cur_col}, 32'd4);

    // Reset in the middle of a byte.
    send_bits(8'hE0, 1'b1, 3);
    rst = 1'b1;
    wait_clks(2);
    check_reset_state("midrst");
    rst = 1'b0;
    spi_cs_n = 1'b1;
    wait_clks(4);
    v0 = valid_cnt;
    expect_write(3'd0, 7'd0, 8'hFF);
    send_byte(8'hFF, 1'b1);
    check("rst_valid_cnt", valid_cnt - v0, 32'd1);
    check("rst_byte", {24'd0, last_byte}, 32'hFF);
    check("rst_cur_col", {25'd0, cur_col}, 32'd1);

    spi_cs_n = 1'b1;
    wait_clks(4);
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
